// File: rtl/aes_axi_lite_regs_pkg.sv
// Register map, bit positions and shared helpers for the AES AXI4-Lite front-end.
package aes_axi_lite_regs_pkg;
  localparam logic [6:0] OFS_CTRL    = 7'h00;
  localparam logic [6:0] OFS_CONFIG  = 7'h04;
  localparam logic [6:0] OFS_STATUS  = 7'h08;
  localparam logic [6:0] OFS_KEY0    = 7'h18;
  localparam logic [6:0] OFS_BLOCK0  = 7'h38;
  localparam logic [6:0] OFS_RESULT0 = 7'h48;

  // Word indices as seen on addr[6:2]
  localparam logic [4:0] W_CTRL    = OFS_CTRL[6:2];
  localparam logic [4:0] W_CONFIG  = OFS_CONFIG[6:2];
  localparam logic [4:0] W_STATUS  = OFS_STATUS[6:2];
  localparam logic [4:0] W_KEY0    = OFS_KEY0[6:2];
  localparam logic [4:0] W_BLOCK0  = OFS_BLOCK0[6:2];
  localparam logic [4:0] W_RESULT0 = OFS_RESULT0[6:2];

  localparam int CTRL_INIT_BIT  = 0;
  localparam int CTRL_NEXT_BIT  = 1;
  localparam int CFG_ENCDEC_BIT = 0;
  localparam int CFG_KEYLEN_BIT = 1;
  localparam int STAT_READY_BIT = 0;
  localparam int STAT_VALID_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/aes_core.sv
// Iterative AES-128/256 cipher: one key-schedule word or one round per clock.
module aes_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         encdec,
  input  logic         init,
  input  logic         next,
  output logic         ready,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [127:0] result,
  output logic         result_valid
);
  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_CIPH} state_t;
  state_t state, state_nxt;

  logic [59:0][31:0] w;
  logic [5:0]   kidx;
  logic [3:0]   round, nr;
  logic         nk8, enc, kexp_last, ciph_last;
  logic [127:0] st, rnd_out, ct;
  logic [31:0]  kt, kw_new;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] y, p;
    y = 8'h01; p = a;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      y = gmul(y, p);
    end
    return y;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 10; k++) if (k < int'(n)) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] a);
    logic [31:0] o;
    for (int k = 0; k < 4; k++) o[8*k +: 8] = sbox(a[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv ? isbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int src;
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [0:3][7:0] m, a;
    logic [7:0] acc;
    m = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      a = s[127-32*c -: 32];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], a[k]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rkey(input logic [59:0][31:0] ww, input logic [3:0] r);
    int b;
    b = 4 * int'(r);
    return {ww[b], ww[b+1], ww[b+2], ww[b+3]};
  endfunction

  assign nr        = nk8 ? 4'd14 : 4'd10;
  assign kexp_last = kidx == (nk8 ? 6'd59 : 6'd43);
  assign ciph_last = enc ? (round == nr) : (round == 4'd0);
  assign ready     = state == S_IDLE;
  assign result    = st;

  always_comb begin
    kt = w[kidx - 6'd1];
    if (nk8 ? (kidx[2:0] == 3'd0) : (kidx[1:0] == 2'd0))
      kt = sub_word({kt[23:0], kt[31:24]}) ^ {rcon(nk8 ? {1'b0, kidx[5:3]} : kidx[5:2]), 24'h0};
    else if (nk8 && kidx[2:0] == 3'd4)
      kt = sub_word(kt);
    kw_new = w[kidx - (nk8 ? 6'd8 : 6'd4)] ^ kt;
  end

  // Decrypt is the straight inverse cipher, reusing the encryption key schedule
  always_comb begin
    if (enc) begin
      ct      = shift_rows(sub_bytes(st, 1'b0), 1'b0);
      rnd_out = (ciph_last ? ct : mix_cols(ct, 1'b0)) ^ rkey(w, round);
    end else begin
      ct      = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rkey(w, round);
      rnd_out = ciph_last ? ct : mix_cols(ct, 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init) state_nxt = S_KEXP; else if (next) state_nxt = S_CIPH;
      S_KEXP:  if (kexp_last) state_nxt = S_IDLE;
      S_CIPH:  if (ciph_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w <= '0; kidx <= '0; round <= '0; nk8 <= 1'b0; enc <= 1'b0;
      st <= '0; result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (init) begin
            for (int j = 0; j < 8; j++) w[j] <= key[255-32*j -: 32];
            nk8          <= keylen;
            kidx         <= keylen ? 6'd8 : 6'd4;
            result_valid <= 1'b0;
          end else if (next) begin
            enc          <= encdec;
            st           <= block ^ rkey(w, encdec ? 4'd0 : nr);
            round        <= encdec ? 4'd1 : nr - 4'd1;
            result_valid <= 1'b0;
          end
        S_KEXP: begin
          w[kidx] <= kw_new;
          kidx    <= kidx + 6'd1;
        end
        S_CIPH: begin
          st    <= rnd_out;
          round <= enc ? round + 4'd1 : round - 4'd1;
          if (ciph_last) result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/aes_axi_lite_regs.sv
// AXI4-Lite register front-end: key/block/config registers, CTRL pulses, AES core.
module aes_axi_lite_regs
  import aes_axi_lite_regs_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 32
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready
);
  logic [0:7][31:0] key_w;
  logic [0:3][31:0] block_w, res_w;
  logic [1:0]       cfg;
  logic             init_p, next_p, core_ready, core_valid;
  logic [127:0]     result;
  logic [4:0]       wa, ra;
  logic             wr_en;
  logic [2:0]       wk, rk;
  logic [1:0]       wb, rb, rr;
  logic [31:0]      rd_mux;
  logic             unused;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

  assign wa    = s00_axi_awaddr[6:2];
  assign ra    = s00_axi_araddr[6:2];
  assign wk    = wa[2:0] - W_KEY0[2:0];
  assign wb    = wa[1:0] - W_BLOCK0[1:0];
  assign rk    = ra[2:0] - W_KEY0[2:0];
  assign rb    = ra[1:0] - W_BLOCK0[1:0];
  assign rr    = ra[1:0] - W_RESULT0[1:0];
  assign res_w = result;
  assign wr_en = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;

  assign s00_axi_wready = s00_axi_awready;
  assign s00_axi_bresp  = RESP_OKAY;
  assign s00_axi_rresp  = RESP_OKAY;

  // Address and data are accepted together so a lone valid never latches half a write
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      init_p <= 1'b0; next_p <= 1'b0;
      cfg <= '0; key_w <= '0; block_w <= '0;
    end else begin
      s00_axi_awready <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
      if (wr_en)               s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
      init_p <= wr_en && wa == W_CTRL && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_INIT_BIT];
      next_p <= wr_en && wa == W_CTRL && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_NEXT_BIT];
      if (wr_en) begin
        if (wa == W_CONFIG && s00_axi_wstrb[0]) cfg <= s00_axi_wdata[1:0];
        if (wa >= W_KEY0 && wa < W_BLOCK0)
          key_w[wk] <= apply_strb(key_w[wk], s00_axi_wdata, s00_axi_wstrb);
        if (wa >= W_BLOCK0 && wa < W_RESULT0)
          block_w[wb] <= apply_strb(block_w[wb], s00_axi_wdata, s00_axi_wstrb);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (ra == W_CONFIG) rd_mux[1:0] = cfg;
    else if (ra == W_STATUS) begin
      rd_mux[STAT_READY_BIT] = core_ready;
      rd_mux[STAT_VALID_BIT] = core_valid;
    end
    else if (ra >= W_KEY0 && ra < W_BLOCK0)                 rd_mux = key_w[rk];
    else if (ra >= W_BLOCK0 && ra < W_RESULT0)              rd_mux = block_w[rb];
    else if (ra >= W_RESULT0 && ra < W_RESULT0 + 5'd4)      rd_mux = res_w[rr];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
      if (s00_axi_arready && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rready) s00_axi_rvalid <= 1'b0;
    end
  end

  aes_core u_core (
    .clk          (s00_axi_aclk),
    .reset_n      (~s00_axi_areset),
    .encdec       (cfg[CFG_ENCDEC_BIT]),
    .init         (init_p),
    .next         (next_p),
    .ready        (core_ready),
    .key          (key_w),
    .keylen       (cfg[CFG_KEYLEN_BIT]),
    .block        (block_w),
    .result       (result),
    .result_valid (core_valid)
  );
endmodule

// File: tb/tb_aes_axi_lite_regs.sv
// Scoreboard bench: tasks queue expected responses, a negedge monitor pops and compares.
module tb_aes_axi_lite_regs;
  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  aes_axi_lite_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready)
  );

  typedef struct { logic [31:0] data; logic [31:0] mask; string nm; } rexp_t;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  rexp_t       e_m;
  int          ncmp = 0, nerr = 0, aw_cnt = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h required %08h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    ncmp++; nerr++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (awready) aw_cnt++;
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        ncmp++; nerr++; $display("FAIL bresp: unexpected response %0d", bresp);
      end else chk("bresp", {30'b0, bresp}, {30'b0, bq.pop_front()});
    end
    if (rvalid && rready) begin
      last_rdata = rdata;
      if (rq.size() == 0) begin
        ncmp++; nerr++; $display("FAIL rdata: unexpected read data %08h", rdata);
      end else begin
        e_m = rq.pop_front();
        if (e_m.mask != 0) begin
          chk(e_m.nm, rdata & e_m.mask, e_m.data);
          chk({e_m.nm, "_rresp"}, {30'b0, rresp}, 32'd0);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead, input int bhold, input string nm);
    int n, c0;
    bq.push_back(2'b00);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1;
    for (int i = 0; i < lead; i++) begin
      step; chk({nm, "_aw_only_noready"}, {31'b0, awready}, 32'd0);
    end
    c0 = aw_cnt;
    wvalid = 1'b1;
    n = 0;
    do begin step; n++; end while (!awready && n < 50);
    if (!awready) begin tmo(nm); awvalid = 1'b0; wvalid = 1'b0; return; end
    chk({nm, "_wready"}, {31'b0, wready}, 32'd1);
    step;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin step; n++; end
    if (!bvalid) begin tmo({nm, "_bvalid"}); return; end
    for (int i = 0; i < bhold; i++) begin
      step; chk({nm, "_bvalid_hold"}, {31'b0, bvalid}, 32'd1);
    end
    bready = 1'b1; step; bready = 1'b0;
    chk({nm, "_single_aw_pulse"}, aw_cnt - c0, 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] mask,
                    input string nm, input int hold);
    int n;
    rexp_t e;
    e.data = exp; e.mask = mask; e.nm = nm;
    rq.push_back(e);
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin step; n++; end while (!arready && n < 50);
    if (!arready) begin tmo(nm); arvalid = 1'b0; return; end
    step;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin step; n++; end
    if (!rvalid) begin tmo({nm, "_rvalid"}); return; end
    for (int i = 0; i < hold; i++) begin
      step; chk({nm, "_rvalid_hold"}, {31'b0, rvalid}, 32'd1);
    end
    rready = 1'b1; step; rready = 1'b0;
  endtask

  task automatic poll(input int bitn, input string nm);
    int k;
    k = 0;
    do begin rd(32'h08, 32'h0, 32'h0, "poll", 0); k++; end
    while (!last_rdata[bitn] && k < 200);
    ncmp++;
    if (!last_rdata[bitn]) begin
      nerr++; $display("FAIL %s: STATUS bit %0d got 0 required 1", nm, bitn);
    end
  endtask

  logic [31:0] key128 [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] pt     [4] = '{32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a};
  logic [31:0] ctx    [4] = '{32'h3ad77bb4, 32'h0d7a3660, 32'ha89ecaf3, 32'h2466ef97};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step;
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_wready",  {31'b0, wready},  32'd0);
    chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    areset = 1'b0;
    step;

    rd(32'h04, 32'h0, '1, "rst_config", 3);
    rd(32'h18, 32'h0, '1, "rst_key0", 3);
    rd(32'h48, 32'h0, '1, "rst_result0", 3);

    wr(32'h18, 32'h2b7e1516, 4'hf, 0, 0, "wr_key0");
    rd(32'h18, 32'h2b7e1516, '1, "rb_key0", 0);
    wr(32'h18, 32'hffffffff, 4'h1, 0, 0, "wr_key0_strb");
    rd(32'h18, 32'h2b7e15ff, '1, "rb_key0_strb", 0);

    // AES-128 encrypt; KEY1 written with a late wvalid and a stalled bready
    wr(32'h18, key128[0], 4'hf, 0, 0, "wr_key0b");
    wr(32'h1c, key128[1], 4'hf, 3, 5, "wr_key1_late_w");
    wr(32'h20, key128[2], 4'hf, 0, 0, "wr_key2");
    wr(32'h24, key128[3], 4'hf, 0, 0, "wr_key3");
    for (int i = 4; i < 8; i++) wr(32'h18 + 32'(4*i), 32'h0, 4'hf, 0, 0, "wr_keyhi");
    wr(32'h04, 32'h1, 4'hf, 0, 0, "wr_cfg_enc");
    wr(32'h00, 32'h1, 4'hf, 0, 0, "wr_init");
    wr(32'h00, 32'h0, 4'hf, 0, 0, "wr_ctrl0");
    poll(0, "init_ready");
    for (int i = 0; i < 4; i++) wr(32'h38 + 32'(4*i), pt[i], 4'hf, 0, 0, "wr_block");
    wr(32'h00, 32'h2, 4'hf, 0, 0, "wr_next");
    wr(32'h00, 32'h0, 4'hf, 0, 0, "wr_ctrl0");
    poll(1, "enc_valid");
    rd(32'h08, 32'h3, '1, "status_enc_done", 0);
    for (int i = 0; i < 4; i++) rd(32'h48 + 32'(4*i), ctx[i], '1, $sformatf("enc_result%0d", i), 0);
    rd(32'h04, 32'h1, '1, "rb_config", 0);
    rd(32'h1c, key128[1], '1, "rb_key1", 0);

    // decrypt the ciphertext back with the same key schedule
    wr(32'h04, 32'h0, 4'hf, 0, 0, "wr_cfg_dec");
    for (int i = 0; i < 4; i++) wr(32'h38 + 32'(4*i), ctx[i], 4'hf, 0, 0, "wr_block_ct");
    wr(32'h00, 32'h2, 4'hf, 0, 0, "wr_next_dec");
    wr(32'h00, 32'h0, 4'hf, 0, 0, "wr_ctrl0");
    poll(1, "dec_valid");
    for (int i = 0; i < 4; i++) rd(32'h48 + 32'(4*i), pt[i], '1, $sformatf("dec_result%0d", i), 0);

    // unmapped address and read-as-zero locations
    wr(32'h60, 32'h12345678, 4'hf, 0, 0, "wr_unmapped");
    rd(32'h60, 32'h0, '1, "rd_unmapped", 0);
    rd(32'h18, key128[0], '1, "key0_after_unmapped", 0);
    rd(32'h38, ctx[0], '1, "block0_after_unmapped", 0);
    rd(32'h00, 32'h0, '1, "rd_ctrl", 0);
    rd(32'h0c, 32'h0, '1, "rd_reserved", 0);

    repeat (4) step;
    chk("read_queue_drained",  32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(bq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
